// File: rtl/player_vertical_motion_if.sv
// Frame-rate signal bundle between the platform detector, the player
// vertical-motion block and the sprite/scroll logic.
interface player_vertical_motion_if;
  logic       VS;
  logic       JumpKey;
  logic [9:0] PlayerX;
  logic [9:0] PlatformX1;
  logic [9:0] PlatformX2;
  logic [9:0] PlatformY;
  logic [9:0] PlayerY;
  logic       onPlatform;
  logic       Airborne;

  modport master (
    output VS, JumpKey, PlayerX, PlatformX1, PlatformX2, PlatformY,
    input  PlayerY, onPlatform, Airborne
  );

  modport slave (
    input  VS, JumpKey, PlayerX, PlatformX1, PlatformX2, PlatformY,
    output PlayerY, onPlatform, Airborne
  );
endinterface

// File: rtl/player_vertical_motion.sv
// Per-frame player vertical physics: gravity, jump and landing, stepped once
// on each falling edge of VS.
module player_vertical_motion #(
  parameter logic [9:0]  START_Y       = 10'd100,
  parameter logic [9:0]  PLAYER_HEIGHT = 10'd40,
  parameter logic [9:0]  GROUND_Y      = 10'd440,
  parameter logic [4:0]  JUMP_V        = 5'd12,
  parameter int unsigned GRAVITY_DIV   = 2,
  parameter logic [4:0]  MAX_FALL_V    = 5'd8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  player_vertical_motion_if.slave  bus
);

  localparam int unsigned GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
  localparam logic [GW-1:0] GCNT_MAX = GW'(GRAVITY_DIV - 1);

  typedef enum logic [1:0] {
    FALL     = 2'd0,
    GROUNDED = 2'd1,
    RISE     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    y_q, y_d;
  logic [4:0]    v_q, v_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          on_ground_q, on_ground_d;
  logic          armed_q, armed_d;
  logic          vs_q;

  logic          tick;
  logic          in_x;
  logic          gcnt_wrap;
  logic [10:0]   feet;
  logic [10:0]   feet_v;
  logic [10:0]   y_fall;
  logic [10:0]   plat_y;
  logic [10:0]   ground_y;
  logic [4:0]    rise_v;

  assign tick      = vs_q & ~bus.VS;
  assign in_x      = (bus.PlayerX >= bus.PlatformX1) && (bus.PlayerX <= bus.PlatformX2);
  assign gcnt_wrap = (gcnt_q == GCNT_MAX);
  assign feet      = {1'b0, y_q} + {1'b0, PLAYER_HEIGHT};
  assign feet_v    = feet + {6'b0, v_q};
  assign y_fall    = {1'b0, y_q} + {6'b0, v_q};
  assign plat_y    = {1'b0, bus.PlatformY};
  assign ground_y  = {1'b0, GROUND_Y};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vs_q        <= 1'b1;
      state_q     <= FALL;
      y_q         <= START_Y;
      v_q         <= '0;
      gcnt_q      <= '0;
      on_ground_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      vs_q        <= bus.VS;
      state_q     <= state_d;
      y_q         <= y_d;
      v_q         <= v_d;
      gcnt_q      <= gcnt_d;
      on_ground_q <= on_ground_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    v_d         = v_q;
    gcnt_d      = gcnt_q;
    on_ground_d = on_ground_q;
    armed_d     = armed_q;
    rise_v      = v_q;

    if (tick) begin
      unique case (state_q)
        FALL: begin
          if (in_x && (feet <= plat_y) && (feet_v >= plat_y)) begin
            y_d         = bus.PlatformY - PLAYER_HEIGHT;
            v_d         = '0;
            gcnt_d      = '0;
            on_ground_d = 1'b0;
            state_d     = GROUNDED;
          end else if (feet_v >= ground_y) begin
            y_d         = GROUND_Y - PLAYER_HEIGHT;
            v_d         = '0;
            gcnt_d      = '0;
            on_ground_d = 1'b1;
            state_d     = GROUNDED;
          end else begin
            y_d = y_fall[9:0];
            if (gcnt_wrap) begin
              gcnt_d = '0;
              v_d    = (v_q >= MAX_FALL_V) ? MAX_FALL_V : v_q + 5'd1;
            end else begin
              gcnt_d = gcnt_q + 1'b1;
            end
          end
        end

        GROUNDED: begin
          if (!bus.JumpKey) armed_d = 1'b1;
          if (!on_ground_q && !in_x) begin
            v_d     = '0;
            gcnt_d  = '0;
            state_d = FALL;
          end else if (bus.JumpKey && armed_q) begin
            v_d     = JUMP_V;
            gcnt_d  = '0;
            armed_d = 1'b0;
            state_d = RISE;
          end
        end

        RISE: begin
          // Hitting the top row kills the remaining upward speed outright.
          if ({5'b0, v_q} > y_q) begin
            y_d    = '0;
            rise_v = '0;
          end else begin
            y_d = y_q - {5'b0, v_q};
            if (gcnt_wrap) begin
              gcnt_d = '0;
              rise_v = (v_q == 5'd0) ? 5'd0 : v_q - 5'd1;
            end else begin
              gcnt_d = gcnt_q + 1'b1;
            end
          end
          v_d = rise_v;
          if (rise_v == 5'd0) begin
            v_d     = '0;
            gcnt_d  = '0;
            state_d = FALL;
          end
        end

        default: state_d = FALL;
      endcase
    end
  end

  assign bus.PlayerY    = y_q;
  assign bus.onPlatform = (state_q == GROUNDED);
  assign bus.Airborne   = (state_q != GROUNDED);

endmodule

// File: tb/tb_player_vertical_motion.sv
// Directed bench for player_vertical_motion: fall, jump arc, re-arm,
// walk-off, floor landing and asynchronous reset.
module tb_player_vertical_motion;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   fall_exp [17];
  int   rise_exp [24];
  int   n;

  player_vertical_motion_if bus ();

  player_vertical_motion #(
    .START_Y       (10'd100),
    .PLAYER_HEIGHT (10'd40),
    .GROUND_Y      (10'd440),
    .JUMP_V        (5'd12),
    .GRAVITY_DIV   (2),
    .MAX_FALL_V    (5'd8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: VS low for several cycles (only one update may result), then high.
  task automatic frame();
    @(negedge Clk) bus.VS = 1'b0;
    repeat (4) @(negedge Clk);
    bus.VS = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fall_exp = '{100, 100, 101, 102, 104, 106, 109, 112, 116, 120,
                 125, 130, 136, 142, 149, 156, 160};
    rise_exp = '{148, 136, 125, 114, 104, 94, 85, 76, 68, 60, 53, 46,
                 40, 34, 29, 24, 20, 16, 13, 10, 8, 6, 5, 4};

    Reset          = 1'b0;
    bus.VS         = 1'b1;
    bus.JumpKey    = 1'b0;
    bus.PlayerX    = 10'd320;
    bus.PlatformX1 = 10'd0;
    bus.PlatformX2 = 10'd639;
    bus.PlatformY  = 10'd200;
    #23;
    chk("reset_y", bus.PlayerY, 100);
    chk("reset_onplat", bus.onPlatform, 0);
    chk("reset_airborne", bus.Airborne, 1);
    @(negedge Clk) Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_no_tick_y", bus.PlayerY, 100);

    // Fall from reset onto the platform at row 200
    for (int i = 0; i < 17; i++) begin
      frame();
      chk($sformatf("fall_y_t%0d", i + 1), bus.PlayerY, fall_exp[i]);
      chk($sformatf("fall_onplat_t%0d", i + 1), bus.onPlatform, (i == 16) ? 1 : 0);
    end

    // Arm with JumpKey low, then jump
    frame();
    chk("arm_grounded", bus.onPlatform, 1);
    chk("arm_y", bus.PlayerY, 160);
    bus.JumpKey = 1'b1;
    frame();
    chk("jump_t1_y", bus.PlayerY, 160);
    chk("jump_t1_airborne", bus.Airborne, 1);
    for (int i = 0; i < 24; i++) begin
      frame();
      chk($sformatf("rise_y_%0d", i + 1), bus.PlayerY, rise_exp[i]);
    end
    chk("apex_airborne", bus.Airborne, 1);
    frame();
    chk("apex_fall_moves0", bus.PlayerY, 4);

    // JumpKey held through landing must not re-jump
    n = 0;
    while (!bus.onPlatform && n < 60) begin
      frame();
      n++;
    end
    chk("reland_onplat", bus.onPlatform, 1);
    chk("reland_y", bus.PlayerY, 160);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk($sformatf("held_key_grounded_%0d", i), bus.onPlatform, 1);
    end
    bus.JumpKey = 1'b0;
    frame();
    chk("rearm_grounded", bus.onPlatform, 1);
    bus.JumpKey = 1'b1;
    frame();
    chk("rejump_airborne", bus.Airborne, 1);
    chk("rejump_y", bus.PlayerY, 160);
    frame();
    chk("rejump_rise_y", bus.PlayerY, 148);

    // Asynchronous reset mid-RISE, between clock edges
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("async_reset_y", bus.PlayerY, 100);
    chk("async_reset_onplat", bus.onPlatform, 0);
    chk("async_reset_airborne", bus.Airborne, 1);
    bus.JumpKey    = 1'b0;
    bus.PlayerX    = 10'd100;
    bus.PlatformX1 = 10'd100;
    bus.PlatformX2 = 10'd300;
    @(negedge Clk) Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_reset_y", bus.PlayerY, 100);

    // Land with PlayerX on the left edge, then walk off past the right edge
    for (int i = 0; i < 17; i++) frame();
    chk("edge_land_y", bus.PlayerY, 160);
    chk("edge_land_onplat", bus.onPlatform, 1);
    bus.PlayerX = 10'd300;
    frame();
    chk("right_edge_stays", bus.onPlatform, 1);
    bus.PlayerX = 10'd301;
    frame();
    chk("walkoff_onplat", bus.onPlatform, 0);
    chk("walkoff_y", bus.PlayerY, 160);
    frame();
    chk("walkoff_moves0", bus.PlayerY, 160);

    // Floor landing with no platform in range
    bus.PlatformX1 = 10'd0;
    bus.PlatformX2 = 10'd0;
    bus.PlayerX    = 10'd320;
    n = 0;
    while (!bus.onPlatform && n < 80) begin
      frame();
      n++;
    end
    chk("floor_onplat", bus.onPlatform, 1);
    chk("floor_y", bus.PlayerY, 400);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk($sformatf("floor_no_walkoff_%0d", i), bus.onPlatform, 1);
    end
    chk("floor_y_hold", bus.PlayerY, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
